wb_stream_writer: RTL

Synthesizable Wishbone B3 master that turns an inbound word stream into incrementing-burst write cycles into a circular memory buffer. It is the initiator end of the streamer's burst-write path: it produces the write bursts that the streamer bench's slave-side reader accepts and checks. Inside the SoC it sits between a sample source, such as the RX FIFO of the radio interface, and the memory bus.

---
 rtl/wb_stream_writer_pkg.sv | 29 ++
 rtl/wb_stream_writer_if.sv | 29 ++
 rtl/wb_stream_writer_fifo.sv | 76 +++++++
 rtl/wb_stream_writer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_writer_pkg.sv
// Shared constants, state encoding and small helpers for the stream writer.
package wb_stream_writer_pkg;

  // Wishbone B3 cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC   = 3'b000;
  localparam logic [2:0] CTI_INC_BURST = 3'b010;
  localparam logic [2:0] CTI_EOB       = 3'b111;

  // Wishbone B3 burst type: only linear bursts are generated
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  // Writer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_BURST = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // Cycle type for a beat inside an incrementing burst
  function automatic logic [2:0] beat_cti(input logic last_beat);
    if (last_beat) begin
      return CTI_EOB;
    end else begin
      return CTI_INC_BURST;
    end
  endfunction

endpackage

// File: rtl/wb_stream_writer_if.sv
// Wishbone B3 bus bundle between the stream writer (master) and memory (slave).
interface wb_stream_writer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat;
  logic [DW/8-1:0] sel;
  logic            we;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output adr, dat, sel, we, cti, bte, cyc, stb,
    input  ack, err, rty
  );

  modport slave (
    input  adr, dat, sel, we, cti, bte, cyc, stb,
    output ack, err, rty
  );

endinterface

// File: rtl/wb_stream_writer_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is always on rd_data.
// full is registered so the upstream ready can be taken straight from it.
module wb_stream_writer_fifo #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic [DW-1:0] rd_data,
  input  logic          rd_en,
  output logic          empty,
  output logic [AW:0]   count
);
  import wb_stream_writer_pkg::*;

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          do_wr;
  logic          do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign empty   = (count == CNT_ZERO);

  // Occupancy after this cycle's write and read
  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd) begin
      count_nxt = count + CNT_ONE;
    end else if (!do_wr && do_rd) begin
      count_nxt = count - CNT_ONE;
    end else begin
      count_nxt = count;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and registered full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
      full   <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
    end
  end

endmodule

// File: rtl/wb_stream_writer.sv
// Wishbone B3 master that drains a word stream into a circular memory buffer
// using incrementing bursts of up to MAX_BURST_LEN beats.
module wb_stream_writer
  import wb_stream_writer_pkg::*;
#(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 6,
  parameter int MAX_BURST_LEN = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [WB_DW-1:0]   stream_s_data_i,
  input  logic               stream_s_valid_i,
  output logic               stream_s_ready_o,
  input  logic               cfg_enable_i,
  input  logic [WB_AW-1:0]   cfg_start_adr_i,
  input  logic [WB_AW-1:0]   cfg_buf_size_i,
  wb_stream_writer_if.master wb,
  output logic               busy_o,
  output logic               wrap_o,
  output logic               err_o
);

  localparam int BYTES = WB_DW / 8;
  localparam int BW    = $clog2(MAX_BURST_LEN + 1);

  localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(BYTES);
  localparam logic [WB_AW-1:0] ADR_MASK = ~(WB_AW'(BYTES - 1));
  localparam logic [WB_AW-1:0] MAX_BLEN = WB_AW'(MAX_BURST_LEN);
  localparam logic [WB_AW-1:0] W_ONE    = WB_AW'(1'b1);
  localparam logic [WB_AW-1:0] W_ZERO   = {WB_AW{1'b0}};
  localparam logic [BW-1:0]    BEAT_ONE = BW'(1'b1);
  localparam logic [BW-1:0]    BEAT_ZERO = {BW{1'b0}};
  localparam logic [WB_DW-1:0] DAT_ZERO = {WB_DW{1'b0}};

  state_t           state;
  state_t           state_nxt;
  logic [WB_AW-1:0] adr;
  logic [WB_AW-1:0] adr_nxt;
  logic [WB_AW-1:0] base;
  logic [WB_AW-1:0] base_nxt;
  logic [WB_AW-1:0] size;
  logic [WB_AW-1:0] size_nxt;
  logic [WB_AW-1:0] rem;
  logic [WB_AW-1:0] rem_nxt;
  logic [BW-1:0]    beat;
  logic [BW-1:0]    beat_nxt;
  logic [WB_AW-1:0] blen;
  logic [WB_AW-1:0] fifo_level;
  logic             cyc;
  logic             cyc_nxt;
  logic [2:0]       cti;
  logic [2:0]       cti_nxt;
  logic             busy;
  logic             busy_nxt;
  logic             wrap;
  logic             wrap_nxt;
  logic             err;
  logic             err_nxt;
  logic             pop;

  logic             fifo_full;
  logic             fifo_empty;
  logic [WB_DW-1:0] fifo_head;
  logic [FIFO_AW:0] fifo_count;

  wb_stream_writer_fifo #(
    .DW (WB_DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .wr_data (stream_s_data_i),
    .wr_en   (stream_s_valid_i),
    .full    (fifo_full),
    .rd_data (fifo_head),
    .rd_en   (pop && !fifo_empty),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign stream_s_ready_o = !fifo_full;
  assign fifo_level       = WB_AW'(fifo_count);

  // Bus outputs come from the cycle/cti/address registers and the FIFO head
  assign wb.adr = adr;
  assign wb.dat = cyc ? fifo_head : DAT_ZERO;
  assign wb.sel = {BYTES{cyc}};
  assign wb.we  = cyc;
  assign wb.cti = cti;
  assign wb.bte = BTE_LINEAR;
  assign wb.cyc = cyc;
  assign wb.stb = cyc;

  assign busy_o = busy;
  assign wrap_o = wrap;
  assign err_o  = err;

  // Length of the next burst: whatever is left of the buffer, capped
  always_comb begin
    blen = MAX_BLEN;
    if (rem < MAX_BLEN) begin
      blen = rem;
    end else begin
      blen = MAX_BLEN;
    end
  end

  // Next-state and datapath decisions for the burst controller
  always_comb begin
    state_nxt = state;
    adr_nxt   = adr;
    base_nxt  = base;
    size_nxt  = size;
    rem_nxt   = rem;
    beat_nxt  = beat;
    wrap_nxt  = 1'b0;
    err_nxt   = err;
    pop       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cfg_enable_i && (cfg_buf_size_i != W_ZERO)) begin
          base_nxt  = cfg_start_adr_i & ADR_MASK;
          size_nxt  = cfg_buf_size_i;
          adr_nxt   = cfg_start_adr_i & ADR_MASK;
          rem_nxt   = cfg_buf_size_i;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (!cfg_enable_i) begin
          state_nxt = ST_IDLE;
        end else if (fifo_level >= blen) begin
          beat_nxt  = blen[BW-1:0];
          state_nxt = ST_BURST;
        end else begin
          state_nxt = ST_WAIT;
        end
      end

      ST_BURST: begin
        // Error beats are not consumed; retry counts as a wait state
        if (wb.err) begin
          err_nxt   = 1'b1;
          state_nxt = ST_HALT;
        end else if (wb.ack && !wb.rty) begin
          pop      = 1'b1;
          adr_nxt  = adr + ADR_STEP;
          rem_nxt  = rem - W_ONE;
          beat_nxt = beat - BEAT_ONE;
          if (beat == BEAT_ONE) begin
            if (rem == W_ONE) begin
              wrap_nxt = 1'b1;
              adr_nxt  = base;
              rem_nxt  = size;
            end else begin
              wrap_nxt = 1'b0;
            end
            if (cfg_enable_i) begin
              state_nxt = ST_WAIT;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            state_nxt = ST_BURST;
          end
        end else begin
          state_nxt = ST_BURST;
        end
      end

      ST_HALT: begin
        if (!cfg_enable_i) begin
          err_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_HALT;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    cyc_nxt  = (state_nxt == ST_BURST);
    busy_nxt = (state_nxt != ST_IDLE);
    if (cyc_nxt) begin
      cti_nxt = beat_cti(beat_nxt == BEAT_ONE);
    end else begin
      cti_nxt = CTI_CLASSIC;
    end
  end

  // Controller state, burst bookkeeping and registered bus/status outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      adr   <= W_ZERO;
      base  <= W_ZERO;
      size  <= W_ZERO;
      rem   <= W_ZERO;
      beat  <= BEAT_ZERO;
      cyc   <= 1'b0;
      cti   <= CTI_CLASSIC;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      adr   <= adr_nxt;
      base  <= base_nxt;
      size  <= size_nxt;
      rem   <= rem_nxt;
      beat  <= beat_nxt;
      cyc   <= cyc_nxt;
      cti   <= cti_nxt;
      busy  <= busy_nxt;
      wrap  <= wrap_nxt;
      err   <= err_nxt;
    end
  end

endmodule
